// File: rtl/de_shift_reader.sv
// Parallel-load, bit-serial read-out register with a valid/ready serial port.
// One edge load latency; ser_valid is held and the word frozen while ser_ready is low.
module de_shift_reader #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             E,
  input  logic             ser_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] shreg_next;
  logic             xfer;

  // The head flop sits at the end the bits leave from; vacated bits fill with 0.
  always_comb begin
    shreg_next = '0;
    if (MSB_FIRST) begin
      shreg_next = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      shreg_next = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  assign ser_out = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
  assign xfer    = ser_valid & ser_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shreg     <= '0;
      count     <= '0;
      ser_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (E) begin
            shreg     <= D;
            count     <= CW'(WIDTH);
            ser_valid <= 1'b1;
            busy      <= 1'b1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          // Loads are ignored here so the word in flight cannot be disturbed.
          if (xfer) begin
            if (count == CW'(1)) begin
              shreg     <= '0;
              count     <= '0;
              ser_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              shreg <= shreg_next;
              count <= count - CW'(1);
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          shreg     <= '0;
          count     <= '0;
          ser_valid <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_de_shift_reader.sv
// Bench for de_shift_reader: MSB-first and LSB-first instances share one stimulus,
// checked every cycle against a bit-queue model plus literal stream expectations.
module tb_de_shift_reader;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] D = 8'h00;
  logic       E = 1'b0;
  logic       ser_ready = 1'b0;

  logic m_out, m_valid, m_busy, m_done;
  logic l_out, l_valid, l_busy, l_done;

  de_shift_reader #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .reset(reset), .D(D), .E(E), .ser_ready(ser_ready),
    .ser_out(m_out), .ser_valid(m_valid), .busy(m_busy), .done(m_done)
  );

  de_shift_reader #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .reset(reset), .D(D), .E(E), .ser_ready(ser_ready),
    .ser_out(l_out), .ser_valid(l_valid), .busy(l_busy), .done(l_done)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: the bits still owed to the consumer, plus a pending done strobe.
  bit qm[$];
  bit ql[$];
  bit dm = 1'b0;
  bit dl = 1'b0;

  logic [7:0] cap_m = 8'h00;
  logic [7:0] cap_l = 8'h00;
  int n_m = 0;
  int n_l = 0;

  logic [3:0] em, el;
  logic [7:0] snap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      qm.delete();
      ql.delete();
      dm = 1'b0;
      dl = 1'b0;
    end else begin
      if (qm.size() > 0) begin
        if (ser_ready) begin
          void'(qm.pop_front());
          if (qm.size() == 0) dm = 1'b1;
        end
      end else if (dm) begin
        dm = 1'b0;
      end else if (E) begin
        for (int i = 0; i < 8; i++) qm.push_back(D[7-i]);
      end
      if (ql.size() > 0) begin
        if (ser_ready) begin
          void'(ql.pop_front());
          if (ql.size() == 0) dl = 1'b1;
        end
      end else if (dl) begin
        dl = 1'b0;
      end else if (E) begin
        for (int i = 0; i < 8; i++) ql.push_back(D[i]);
      end
    end
  end

  // Inputs change just after rising edges, so at the falling edge ser_ready
  // is the value the next rising edge will see.
  initial forever begin
    @(negedge clk);
    em = {(qm.size() > 0) ? qm[0] : 1'b0, qm.size() > 0, qm.size() > 0, dm};
    el = {(ql.size() > 0) ? ql[0] : 1'b0, ql.size() > 0, ql.size() > 0, dl};
    check("msb_cycle", 32'({m_out, m_valid, m_busy, m_done}), 32'(em));
    check("lsb_cycle", 32'({l_out, l_valid, l_busy, l_done}), 32'(el));
    if (m_valid && ser_ready) begin
      cap_m = {cap_m[6:0], m_out};
      n_m++;
    end
    if (l_valid && ser_ready) begin
      cap_l = {cap_l[6:0], l_out};
      n_l++;
    end
  end

  initial forever begin
    @(posedge clk);
    #9;
    snap = {m_out, m_valid, m_busy, m_done, l_out, l_valid, l_busy, l_done};
    #2;
    check("fall_stable", 32'({m_out, m_valid, m_busy, m_done, l_out, l_valid, l_busy, l_done}),
          32'(snap));
  end

  task automatic run_word(input string name, input logic [7:0] d, input int stall_at,
                          input int stall_len, input bit hammer, input logic [7:0] exp_m,
                          input logic [7:0] exp_l, input int exp_lat);
    int n0m, n0l, cyc, stalled;
    bit seen;
    n0m = n_m;
    n0l = n_l;
    cyc = 0;
    stalled = 0;
    seen = 1'b0;
    D = d;
    E = 1'b1;
    ser_ready = 1'b1;
    while (!seen && cyc < 40) begin
      tick();
      cyc++;
      if (m_done) begin
        seen = 1'b1;
        check({name, "_lsb_done"}, 32'(l_done), 32'd1);
      end
      E = hammer && (n_m - n0m) >= 1 && (n_m - n0m) <= 4;
      if (E) D = 8'hFF;
      if (stall_len > 0 && (n_m - n0m) == stall_at && stalled < stall_len) begin
        ser_ready = 1'b0;
        stalled++;
      end else begin
        ser_ready = 1'b1;
      end
    end
    E = 1'b0;
    ser_ready = 1'b1;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done not seen after %0d cycles, required by %0d", name, cyc, exp_lat);
    end
    check({name, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({name, "_bits_m"}, 32'(n_m - n0m), 32'd8);
    check({name, "_bits_l"}, 32'(n_l - n0l), 32'd8);
    check({name, "_stream_m"}, 32'(cap_m), 32'(exp_m));
    check({name, "_stream_l"}, 32'(cap_l), 32'(exp_l));
    tick();
    check({name, "_idle"}, 32'({m_out, m_valid, m_busy, m_done, l_out, l_valid, l_busy, l_done}),
          32'd0);
  endtask

  initial begin
    int n0, guard;

    // Reset held with a load request pending.
    reset = 1'b0;
    E = 1'b1;
    D = 8'hC1;
    ser_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold", 32'({m_out, m_valid, m_busy, m_done, l_out, l_valid, l_busy, l_done}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    E = 1'b0;
    #1;
    check("rst_release", 32'({m_out, m_valid, m_busy, m_done, l_out, l_valid, l_busy, l_done}), 32'd0);
    tick();

    run_word("basic", 8'hC1, 0, 0, 1'b0, 8'hC1, 8'h83, 9);
    run_word("stall", 8'hC1, 3, 3, 1'b0, 8'hC1, 8'h83, 12);
    run_word("hammer", 8'hC1, 0, 0, 1'b1, 8'hC1, 8'h83, 9);
    run_word("fresh", 8'h1E, 0, 0, 1'b0, 8'h1E, 8'h78, 9);

    // Async reset in the middle of a word.
    n0 = n_m;
    D = 8'hC1;
    E = 1'b1;
    ser_ready = 1'b1;
    tick();
    E = 1'b0;
    guard = 0;
    while ((n_m - n0) < 3 && guard < 20) begin
      tick();
      guard++;
    end
    check("mid_bits", 32'(n_m - n0), 32'd3);
    #4;
    reset = 1'b0;
    #1;
    check("mid_rst", 32'({m_out, m_valid, m_busy, m_done, l_out, l_valid, l_busy, l_done}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check("post_rst_idle", 32'({m_valid, m_busy, m_done, l_valid, l_busy, l_done}), 32'd0);

    run_word("after_rst", 8'h5A, 0, 0, 1'b0, 8'h5A, 8'h5A, 9);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
